// File: rtl/rv32_pkg.sv
// Shared RV32I decode/execute definitions: opcodes, ALU/branch/memory
// enums and the decode-to-execute bundle.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_JAL, BR_JALR, BR_EQ, BR_LT, BR_LTU
  } branch_op_e;

  typedef enum logic [1:0] {
    MW_BYTE, MW_HALF, MW_WORD
  } mem_width_e;

  typedef struct packed {
    logic       valid;
    logic [31:0] pc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] imm;
    alu_op_e    alu_op;
    logic       src1_pc;
    logic       src2_imm;
    branch_op_e branch_op;
    logic       mem_read;
    logic       mem_write;
    mem_width_e mem_width;
    logic       zero_ext;
    logic       rd_write;
    logic       illegal;
  } id_ex_t;

  // alt selects SUB/SRA (funct7[5]) where it is meaningful
  function automatic alu_op_e alu_from_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    unique case (f3)
      3'b000: alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001: alu_from_f3 = ALU_SLL;
      3'b010: alu_from_f3 = ALU_SLT;
      3'b011: alu_from_f3 = ALU_SLTU;
      3'b100: alu_from_f3 = ALU_XOR;
      3'b101: alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110: alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_regs.sv
// 32x32 register file: two combinational read ports with write bypass,
// one synchronous write port; x0 reads 0, contents are not reset.
module rv32_regs (
  input  logic        clk,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        rd_write,
  input  logic [4:0]  rd,
  input  logic [31:0] rd_value,
  output logic [31:0] rs1_value,
  output logic [31:0] rs2_value
);

  logic [31:0] mem [32];
  logic        wr;

  assign wr = rd_write && (rd != 5'd0);

  always_ff @(posedge clk) begin
    if (wr) mem[rd] <= rd_value;
  end

  always_comb begin
    rs1_value = mem[rs1];
    if (rs1 == 5'd0)
      rs1_value = '0;
    else if (wr && rd == rs1)
      rs1_value = rd_value;
  end

  always_comb begin
    rs2_value = mem[rs2];
    if (rs2 == 5'd0)
      rs2_value = '0;
    else if (wr && rd == rs2)
      rs2_value = rd_value;
  end

endmodule

// File: rtl/rv32_decode.sv
// RV32I decode stage: decodes pc_in/instr_in, reads operands from
// rv32_regs and registers the result with stall/flush control.
module rv32_decode
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        rd_write_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] rd_value_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic [31:0] rs1_value_out,
  output logic [31:0] rs2_value_out,
  output logic [31:0] imm_out,
  output logic [3:0]  alu_op_out,
  output logic        alu_src1_pc_out,
  output logic        alu_src2_imm_out,
  output logic [2:0]  branch_op_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [1:0]  mem_width_out,
  output logic        mem_zero_ext_out,
  output logic        rd_write_out,
  output logic        illegal_out
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad;
  id_ex_t      d, q;

  assign opc = instr_in[6:0];
  assign f3  = instr_in[14:12];
  assign f7  = instr_in[31:25];

  assign imm_i = {{21{instr_in[31]}}, instr_in[30:20]};
  assign imm_s = {{21{instr_in[31]}}, instr_in[30:25],
                  instr_in[11:7]};
  assign imm_b = {{20{instr_in[31]}}, instr_in[7],
                  instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u = {instr_in[31:12], 12'd0};
  assign imm_j = {{12{instr_in[31]}}, instr_in[19:12],
                  instr_in[20], instr_in[30:21], 1'b0};

  rv32_regs u_regs (
    .clk       (clk),
    .rs1       (instr_in[19:15]),
    .rs2       (instr_in[24:20]),
    .rd_write  (rd_write_in),
    .rd        (rd_in),
    .rd_value  (rd_value_in),
    .rs1_value (rs1_v),
    .rs2_value (rs2_v)
  );

  always_comb begin
    d           = '0;
    bad         = 1'b0;
    d.valid     = 1'b1;
    d.pc        = pc_in;
    d.rs1       = instr_in[19:15];
    d.rs2       = instr_in[24:20];
    d.rd        = instr_in[11:7];
    d.rs1_value = rs1_v;
    d.rs2_value = rs2_v;
    d.alu_op    = ALU_ADD;
    d.branch_op = BR_NONE;
    d.mem_width = MW_BYTE;
    unique case (1'b1)
      (opc == OPC_LUI): begin
        d.imm       = imm_u;
        d.src2_imm  = 1'b1;
        d.rd_write  = 1'b1;
        d.rs1       = '0;
        d.rs1_value = '0;
      end
      (opc == OPC_AUIPC): begin
        d.imm      = imm_u;
        d.src1_pc  = 1'b1;
        d.src2_imm = 1'b1;
        d.rd_write = 1'b1;
      end
      (opc == OPC_JAL): begin
        d.imm       = imm_j;
        d.src1_pc   = 1'b1;
        d.rd_write  = 1'b1;
        d.branch_op = BR_JAL;
      end
      (opc == OPC_JALR): begin
        d.imm       = imm_i;
        d.src1_pc   = 1'b1;
        d.rd_write  = 1'b1;
        d.branch_op = BR_JALR;
        bad         = (f3 != 3'b000);
      end
      (opc == OPC_BRANCH): begin
        d.imm    = imm_b;
        d.alu_op = ALU_SUB;
        unique case (f3[2:1])
          2'b00:   d.branch_op = BR_EQ;
          2'b10:   d.branch_op = BR_LT;
          2'b11:   d.branch_op = BR_LTU;
          default: bad = 1'b1;
        endcase
      end
      (opc == OPC_LOAD): begin
        d.imm       = imm_i;
        d.src2_imm  = 1'b1;
        d.mem_read  = 1'b1;
        d.rd_write  = 1'b1;
        d.mem_width = mem_width_e'(f3[1:0]);
        d.zero_ext  = f3[2];
        bad = (f3 == 3'b011) || (f3 == 3'b110) ||
              (f3 == 3'b111) || (f3 == 3'b010 && f3[2]);
      end
      (opc == OPC_STORE): begin
        d.imm       = imm_s;
        d.src2_imm  = 1'b1;
        d.mem_write = 1'b1;
        d.mem_width = mem_width_e'(f3[1:0]);
        bad = f3[2] || (f3[1:0] == 2'b11);
      end
      (opc == OPC_OPIMM): begin
        d.imm      = imm_i;
        d.src2_imm = 1'b1;
        d.rd_write = 1'b1;
        // only shifts carry funct7; SRAI is the sole alternate form
        d.alu_op = alu_from_f3(f3, f3 == 3'b101 && f7[5]);
        if (f3 == 3'b001)
          bad = (f7 != 7'd0);
        else if (f3 == 3'b101)
          bad = (f7 != 7'd0) && (f7 != 7'h20);
      end
      (opc == OPC_OP): begin
        d.rd_write = 1'b1;
        d.alu_op   = alu_from_f3(f3, f7[5]);
        bad = !((f7 == 7'd0) ||
                (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      (opc == OPC_FENCE): begin
      end
      (opc == OPC_SYSTEM): begin
        // ECALL/EBREAK are NOPs; anything else (CSR ops) is illegal
        bad = (instr_in[31:21] != '0) || (instr_in[19:7] != '0);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      d.illegal   = 1'b1;
      d.rd_write  = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
      d.branch_op = BR_NONE;
    end
    if (d.rd == 5'd0) d.rd_write = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= '0;
    else if (flush_in)
      q <= '0;
    else if (!stall_in)
      q <= valid_in ? d : '0;
  end

  assign valid_out        = q.valid;
  assign pc_out           = q.pc;
  assign rs1_out          = q.rs1;
  assign rs2_out          = q.rs2;
  assign rd_out           = q.rd;
  assign rs1_value_out    = q.rs1_value;
  assign rs2_value_out    = q.rs2_value;
  assign imm_out          = q.imm;
  assign alu_op_out       = q.alu_op;
  assign alu_src1_pc_out  = q.src1_pc;
  assign alu_src2_imm_out = q.src2_imm;
  assign branch_op_out    = q.branch_op;
  assign mem_read_out     = q.mem_read;
  assign mem_write_out    = q.mem_write;
  assign mem_width_out    = q.mem_width;
  assign mem_zero_ext_out = q.zero_ext;
  assign rd_write_out     = q.rd_write;
  assign illegal_out      = q.illegal;

endmodule

// File: tb/tb_rv32_decode.sv
// Directed bench for rv32_decode: hand-encoded RV32I vectors,
// stall/flush, writeback bypass and asynchronous reset.
module tb_rv32_decode;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        stall_in;
  logic        flush_in;
  logic        rd_write_in;
  logic [4:0]  rd_in;
  logic [31:0] rd_value_in;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [31:0] rs1_value_out, rs2_value_out;
  logic [31:0] imm_out;
  logic [3:0]  alu_op_out;
  logic        alu_src1_pc_out, alu_src2_imm_out;
  logic [2:0]  branch_op_out;
  logic        mem_read_out, mem_write_out;
  logic [1:0]  mem_width_out;
  logic        mem_zero_ext_out;
  logic        rd_write_out;
  logic        illegal_out;

  int n_vec = 0;
  int n_err = 0;

  rv32_decode dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .valid_in         (valid_in),
    .pc_in            (pc_in),
    .instr_in         (instr_in),
    .stall_in         (stall_in),
    .flush_in         (flush_in),
    .rd_write_in      (rd_write_in),
    .rd_in            (rd_in),
    .rd_value_in      (rd_value_in),
    .valid_out        (valid_out),
    .pc_out           (pc_out),
    .rs1_out          (rs1_out),
    .rs2_out          (rs2_out),
    .rd_out           (rd_out),
    .rs1_value_out    (rs1_value_out),
    .rs2_value_out    (rs2_value_out),
    .imm_out          (imm_out),
    .alu_op_out       (alu_op_out),
    .alu_src1_pc_out  (alu_src1_pc_out),
    .alu_src2_imm_out (alu_src2_imm_out),
    .branch_op_out    (branch_op_out),
    .mem_read_out     (mem_read_out),
    .mem_write_out    (mem_write_out),
    .mem_width_out    (mem_width_out),
    .mem_zero_ext_out (mem_zero_ext_out),
    .rd_write_out     (rd_write_out),
    .illegal_out      (illegal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] ins);
    valid_in = 1'b1;
    pc_in    = pc;
    instr_in = ins;
  endtask

  initial begin
    reset_n = 0; valid_in = 0; pc_in = 0; instr_in = 0;
    stall_in = 0; flush_in = 0;
    rd_write_in = 0; rd_in = 0; rd_value_in = 0;
    step(); step();
    chk("rst_valid", valid_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_imm", imm_out, 0);
    chk("rst_br", branch_op_out, 0);
    chk("rst_rdw", rd_write_out, 0);
    reset_n = 1;

    // ADDI x1,x0,-5
    put(32'h100, 32'hFFB00093);
    step();
    chk("addi_valid", valid_out, 1);
    chk("addi_pc", pc_out, 32'h100);
    chk("addi_rd", rd_out, 1);
    chk("addi_imm", imm_out, 32'hFFFFFFFB);
    chk("addi_alu", alu_op_out, 0);
    chk("addi_src2", alu_src2_imm_out, 1);
    chk("addi_rdw", rd_write_out, 1);
    chk("addi_rs1v", rs1_value_out, 0);
    chk("addi_ill", illegal_out, 0);

    // ADD x6,x5,x5 with x5 written the same cycle
    put(32'h104, 32'h00528333);
    rd_write_in = 1; rd_in = 5; rd_value_in = 32'h12345678;
    step();
    rd_write_in = 0;
    chk("byp_rs1v", rs1_value_out, 32'h12345678);
    chk("byp_rs2v", rs2_value_out, 32'h12345678);
    chk("add_imm", imm_out, 0);
    chk("add_src2", alu_src2_imm_out, 0);

    // SUB x7,x5,x0 reads stored x5
    put(32'h108, 32'h400283B3);
    step();
    chk("sub_rs1v", rs1_value_out, 32'h12345678);
    chk("sub_alu", alu_op_out, 1);

    // BEQ x0,x0,-8
    put(32'h10C, 32'hFE000CE3);
    step();
    chk("beq_imm", imm_out, 32'hFFFFFFF8);
    chk("beq_br", branch_op_out, 3);
    chk("beq_rdw", rd_write_out, 0);

    // LBU x3,4(x1)
    put(32'h110, 32'h0040C183);
    step();
    chk("lbu_rd", mem_read_out, 1);
    chk("lbu_w", mem_width_out, 0);
    chk("lbu_zx", mem_zero_ext_out, 1);
    chk("lbu_imm", imm_out, 4);

    // SW x2,-4(x1)
    put(32'h114, 32'hFE20AE23);
    step();
    chk("sw_wr", mem_write_out, 1);
    chk("sw_w", mem_width_out, 2);
    chk("sw_imm", imm_out, 32'hFFFFFFFC);
    chk("sw_rdw", rd_write_out, 0);

    // LUI x4,0xABCDE
    put(32'h118, 32'hABCDE237);
    step();
    chk("lui_imm", imm_out, 32'hABCDE000);
    chk("lui_rs1v", rs1_value_out, 0);
    chk("lui_pc", alu_src1_pc_out, 0);

    // AUIPC x4,1
    put(32'h11C, 32'h00001217);
    step();
    chk("auipc_imm", imm_out, 32'h00001000);
    chk("auipc_pc", alu_src1_pc_out, 1);

    // JAL x1,+16 then JAL x0,+16
    put(32'h120, 32'h010000EF);
    step();
    chk("jal_imm", imm_out, 32'h10);
    chk("jal_br", branch_op_out, 1);
    chk("jal_rdw", rd_write_out, 1);
    put(32'h124, 32'h0100006F);
    step();
    chk("jalx0_rdw", rd_write_out, 0);

    // all-zero word is illegal
    put(32'h128, 32'h00000000);
    step();
    chk("ill_flag", illegal_out, 1);
    chk("ill_rdw", rd_write_out, 0);
    chk("ill_valid", valid_out, 1);

    // ECALL is a NOP
    put(32'h12C, 32'h00000073);
    step();
    chk("ecall_ill", illegal_out, 0);
    chk("ecall_rdw", rd_write_out, 0);

    // write to x0 is discarded; ADD x8,x0,x0
    put(32'h130, 32'h00000433);
    rd_write_in = 1; rd_in = 0; rd_value_in = 32'hFFFFFFFF;
    step();
    rd_write_in = 0;
    chk("x0_byp", rs1_value_out, 0);
    step();
    chk("x0_rd", rs1_value_out, 0);

    // stall: capture ADD x6,x5,x5, then freeze while x5 changes
    put(32'h200, 32'h00528333);
    step();
    stall_in = 1;
    rd_write_in = 1; rd_in = 5; rd_value_in = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      put(32'h300 + 32'(i * 4), 32'hFE000CE3);
      step();
      chk("stall_pc", pc_out, 32'h200);
      chk("stall_rs1v", rs1_value_out, 32'h12345678);
      chk("stall_br", branch_op_out, 0);
    end
    rd_write_in = 0;
    flush_in = 1;
    step();
    chk("flush_valid", valid_out, 0);
    chk("flush_rdw", rd_write_out, 0);
    flush_in = 0; stall_in = 0;
    put(32'h210, 32'h00528333);
    step();
    chk("stallwr_rs1v", rs1_value_out, 32'hDEADBEEF);

    // bubble on valid_in=0
    put(32'h214, 32'hFFB00093);
    valid_in = 0;
    step();
    chk("bub_valid", valid_out, 0);
    chk("bub_rdw", rd_write_out, 0);

    // asynchronous reset between edges, released mid-stall
    put(32'h218, 32'hFFB00093);
    step();
    chk("pre_rst_valid", valid_out, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_valid", valid_out, 0);
    chk("arst_imm", imm_out, 0);
    chk("arst_pc", pc_out, 0);
    #2 reset_n = 1;
    stall_in = 1;
    step();
    chk("rst_stall_valid", valid_out, 0);
    stall_in = 0;
    step();
    chk("post_valid", valid_out, 1);
    chk("post_imm", imm_out, 32'hFFFFFFFB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
